// File: rtl/mul_seq_pkg.sv
// Shared types and tables for the sequential 8x8 multiplier: FSM states,
// per-step nibble selection for both issue orders, and partial-product shifts.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Which nibble of each operand feeds the 4x4 core in a given step.
    typedef struct packed {
        logic a_hi;
        logic b_hi;
    } nib_sel_t;

    localparam nib_sel_t SEL_LL = 2'b00;
    localparam nib_sel_t SEL_LH = 2'b01;
    localparam nib_sel_t SEL_HL = 2'b10;
    localparam nib_sel_t SEL_HH = 2'b11;

    // Indexed by step counter; entry [0] is issued first.
    localparam nib_sel_t [3:0] SEL_TABLE_ORD0 = {SEL_HH, SEL_HL, SEL_LH, SEL_LL};
    localparam nib_sel_t [3:0] SEL_TABLE_ORD1 = {SEL_LL, SEL_LH, SEL_HL, SEL_HH};

    localparam logic [3:0] SHIFT_LL = 4'd0;
    localparam logic [3:0] SHIFT_LH = 4'd4;
    localparam logic [3:0] SHIFT_HL = 4'd4;
    localparam logic [3:0] SHIFT_HH = 4'd8;

    function automatic nib_sel_t nib_sel(input logic order, input logic [1:0] step);
        return order ? SEL_TABLE_ORD1[step] : SEL_TABLE_ORD0[step];
    endfunction

    function automatic logic [3:0] shift_of(input nib_sel_t sel);
        logic [3:0] sh;
        case (sel)
            SEL_LL:  sh = SHIFT_LL;
            SEL_LH:  sh = SHIFT_LH;
            SEL_HL:  sh = SHIFT_HL;
            default: sh = SHIFT_HH;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/seq_mul8u_ctrl_rm4um.sv
// Purpose: combinational 4x4 unsigned multiplier core.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module RM4uM (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/seq_mul8u_ctrl.sv
// Purpose: 8x8 unsigned multiply by reusing one 4x4 core over four CALC cycles.
// Latency: out_valid 4 rising edges after accept; next accept no sooner than 6 cycles later.
// Backpressure: DONE holds out/out_valid until out_ready; in_ready only in IDLE.
module seq_mul8u_ctrl
    import mul_seq_pkg::*;
#(
    parameter int ORDER = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic        busy
);

    state_t      state, next_state;
    logic [1:0]  step;
    logic [7:0]  a_q, b_q;
    logic [15:0] acc;

    nib_sel_t    sel;
    logic [3:0]  nib_a, nib_b;
    logic [7:0]  core_p;
    logic [15:0] term;
    logic        accept;

    assign sel   = nib_sel(ORDER != 0, step);
    assign nib_a = sel.a_hi ? a_q[7:4] : a_q[3:0];
    assign nib_b = sel.b_hi ? b_q[7:4] : b_q[3:0];

    RM4uM u_core (
        .a (nib_a),
        .b (nib_b),
        .p (core_p)
    );

    assign term = {8'h00, core_p} << shift_of(sel);

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        out        = 16'h0000;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid) next_state = CALC;
            end
            CALC: begin
                if (step == 2'd3) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out       = acc;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= 2'd0;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            acc   <= 16'h0000;
        end else begin
            state <= next_state;
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                acc  <= 16'h0000;
                step <= 2'd0;
            end else if (state == CALC) begin
                // Sum never exceeds 0xFE01, so the 16-bit add cannot overflow.
                acc  <= acc + term;
                step <= step + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul8u_ctrl.sv
// Directed bench for seq_mul8u_ctrl; both ORDER variants driven in lockstep.
module tb_seq_mul8u_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a, b;
    logic        in_ready0, out_valid0, busy0;
    logic        in_ready1, out_valid1, busy1;
    logic [15:0] out0, out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mul8u_ctrl #(.ORDER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .out(out0), .busy(busy0)
    );

    seq_mul8u_ctrl #(.ORDER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .out(out1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic ir, input logic ov,
                            input logic bs, input logic [15:0] o);
        chk({tag, ".in_ready0"},  {15'd0, in_ready0},  {15'd0, ir});
        chk({tag, ".in_ready1"},  {15'd0, in_ready1},  {15'd0, ir});
        chk({tag, ".out_valid0"}, {15'd0, out_valid0}, {15'd0, ov});
        chk({tag, ".out_valid1"}, {15'd0, out_valid1}, {15'd0, ov});
        chk({tag, ".busy0"},      {15'd0, busy0},      {15'd0, bs});
        chk({tag, ".busy1"},      {15'd0, busy1},      {15'd0, bs});
        chk({tag, ".out0"},       out0,                o);
        chk({tag, ".out1"},       out1,                o);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation with out_ready held high: accept, 4-edge latency, handshake.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [15:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ia;
        b = ib;
        tick();
        in_valid = 1'b0;
        a = ~ia;
        b = ~ib;
        chk_ctrl({tag, ".acc"}, 1'b0, 1'b0, 1'b1, 16'h0000);
        repeat (3) begin
            tick();
            chk_ctrl({tag, ".calc"}, 1'b0, 1'b0, 1'b1, 16'h0000);
        end
        tick();
        chk_ctrl({tag, ".done"}, 1'b0, 1'b1, 1'b1, exp);
        tick();
        chk_ctrl({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        int          guard;
        bit          got;
        logic [7:0]  sa, sb;
        logic [15:0] se;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #1;
        chk_ctrl("reset", 1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Zero operands, latency and re-ready timing.
        run_op("zero", 8'h00, 8'h00, 16'h0000);

        // Maximum operands on both issue orders.
        run_op("max", 8'hFF, 8'hFF, 16'hFE01);

        // Output stall for three cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h12;
        b = 8'h34;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        repeat (3) begin
            chk_ctrl("stall", 1'b0, 1'b1, 1'b1, 16'h03A8);
            tick();
        end
        chk_ctrl("stall.last", 1'b0, 1'b1, 1'b1, 16'h03A8);
        out_ready = 1'b1;
        tick();
        chk_ctrl("stall.idle", 1'b1, 1'b0, 1'b0, 16'h0000);

        // Offer while busy is ignored; in-flight result unaffected.
        in_valid = 1'b1;
        a = 8'h21;
        b = 8'h03;
        tick();
        a = 8'h0F;
        b = 8'hF0;
        repeat (4) tick();
        chk_ctrl("busyoffer.done", 1'b0, 1'b1, 1'b1, 16'h0063);
        tick();
        chk_ctrl("busyoffer.idle", 1'b1, 1'b0, 1'b0, 16'h0000);
        run_op("reoffer", 8'h0F, 8'hF0, 16'h0E10);

        // Reset asserted during CALC step 2.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'hAB;
        b = 8'hCD;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk_ctrl("midreset", 1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (4) begin
            tick();
            chk_ctrl("inreset", 1'b1, 1'b0, 1'b0, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_ctrl("postreset", 1'b1, 1'b0, 1'b0, 16'h0000);
        run_op("after_reset", 8'h80, 8'h02, 16'h0100);

        // Back-to-back sampled sweep with random output backpressure.
        for (int i = 0; i < 2000; i++) begin
            int ib;
            ib = (i * 37) + 11 + (i / 256);
            sa = i[7:0];
            sb = ib[7:0];
            se = 16'(sa) * 16'(sb);
            chk("sweep.in_ready", {15'd0, in_ready0 & in_ready1}, 16'h0001);
            in_valid = 1'b1;
            a = sa;
            b = sb;
            tick();
            in_valid = 1'b0;
            a = 8'h5A;
            b = 8'hA5;
            got   = 1'b0;
            guard = 0;
            while (!got && guard < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid0 && out_ready) begin
                    chk("sweep.out0", out0, se);
                    chk("sweep.out1", out1, se);
                    chk("sweep.valid1", {15'd0, out_valid1}, 16'h0001);
                    got = 1'b1;
                end
                tick();
                guard++;
            end
            if (!got) begin
                chk("sweep.timeout", 16'h0000, 16'h0001);
                break;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
